// File: rtl/noc_link_tx_pkg.sv
// rtl/noc_link_tx_pkg.sv - shared NoC sizing constants and link status encoding
package noc_link_tx_pkg;

  localparam int PAYLOAD_SIZE = 6;
  localparam int ADDR_BITS    = 2;
  localparam int FIFO_LOG2    = 2;
  localparam int FIFO_DEPTH   = 1 << FIFO_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_STARVED = 2'd2
  } link_state_e;

  // A sending cycle wins over a blocked one; everything else reads as idle.
  function automatic link_state_e link_status(input logic send, input logic blocked);
    if (send)
      return ST_SEND;
    else if (blocked)
      return ST_STARVED;
    else
      return ST_IDLE;
  endfunction

endpackage

// File: rtl/noc_link_tx_if.sv
// rtl/noc_link_tx_if.sv - local FIFO read side plus inter-router link wires
interface noc_link_tx_if #(
  parameter int FLIT_W = 8
);

  logic              fifo_empty;
  logic [FLIT_W-1:0] fifo_item;
  logic              fifo_read;
  logic              link_valid;
  logic [FLIT_W-1:0] link_flit;
  logic              credit_in;

  modport master (
    input  fifo_empty, fifo_item, credit_in,
    output fifo_read, link_valid, link_flit
  );

  modport slave (
    output fifo_empty, fifo_item, credit_in,
    input  fifo_read, link_valid, link_flit
  );

endinterface

// File: rtl/noc_link_tx_credit_counter.sv
// rtl/noc_link_tx_credit_counter.sv - saturating credit counter with sticky overflow flag
module noc_link_tx_credit_counter #(
  parameter int CREDITS = 3,
  parameter int CRED_W  = $clog2(CREDITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_i,
  input  logic              inc_i,
  output logic [CRED_W-1:0] count_o,
  output logic              err_o
);

  logic [CRED_W-1:0] count_q, count_d;
  logic              err_q;
  logic              overflow;

  // Simultaneous consume and return cancel; a return at full count is dropped and flagged.
  always_comb begin
    count_d  = count_q;
    overflow = 1'b0;
    if (inc_i && !dec_i) begin
      if (count_q == CRED_W'(CREDITS))
        overflow = 1'b1;
      else
        count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= CRED_W'(CREDITS);
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (overflow)
        err_q <= 1'b1;
    end
  end

  assign count_o = count_q;
  assign err_o   = err_q;

endmodule

// File: rtl/noc_link_tx.sv
// rtl/noc_link_tx.sv - credit-based link transmitter draining a local FIFO onto a router link
module noc_link_tx
  import noc_link_tx_pkg::*;
#(
  parameter int FLIT_W  = PAYLOAD_SIZE + ADDR_BITS,
  parameter int CREDITS = FIFO_DEPTH - 1,
  parameter int CRED_W  = $clog2(CREDITS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  noc_link_tx_if.master     link,
  output logic [CRED_W-1:0] credits,
  output logic [1:0]        state,
  output logic              credit_err
);

  logic              send;
  logic              blocked;
  logic              have_credit;
  logic              valid_q;
  logic [FLIT_W-1:0] flit_q;
  link_state_e       state_q;

  // Pops only with a registered credit in hand, so credit_in never reaches an output combinationally.
  assign have_credit = (credits != '0);
  assign send        = reset && enable && !link.fifo_empty && have_credit;
  assign blocked     = reset && enable && !link.fifo_empty && !have_credit;

  noc_link_tx_credit_counter #(
    .CREDITS (CREDITS),
    .CRED_W  (CRED_W)
  ) u_credit_counter (
    .clk     (clk),
    .rst_n   (reset),
    .dec_i   (send),
    .inc_i   (link.credit_in),
    .count_o (credits),
    .err_o   (credit_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      flit_q  <= '0;
      state_q <= ST_IDLE;
    end else begin
      valid_q <= send;
      if (send)
        flit_q <= link.fifo_item;
      state_q <= link_status(send, blocked);
    end
  end

  assign link.fifo_read  = send;
  assign link.link_valid = valid_q;
  assign link.link_flit  = flit_q;
  assign state           = state_q;

endmodule

// File: tb/tb_noc_link_tx.sv
// tb/tb_noc_link_tx.sv - self-checking bench for noc_link_tx with queue-based FIFO models
module tb_noc_link_tx;

  typedef logic [7:0] flit_t;

  localparam int CREDITS   = 3;
  localparam int DOWN_CAP  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] credits;
  logic [1:0] state;
  logic       credit_err;

  int checks   = 0;
  int failures = 0;

  flit_t up_q[$];
  flit_t down_q[$];
  flit_t order_q[$];
  flit_t recv_q[$];

  int    m_credits;
  bit    m_err;
  bit    m_valid;
  flit_t m_flit;
  int    m_state;
  bit    cpipe0, cpipe1;
  bit    down_en;
  bit    spur;
  int    overlap_hits = 0;

  always #5 clk = ~clk;

  noc_link_tx_if #(.FLIT_W(8)) link();

  noc_link_tx #(
    .FLIT_W  (8),
    .CREDITS (CREDITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .link       (link),
    .credits    (credits),
    .state      (state),
    .credit_err (credit_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    link.fifo_empty = (up_q.size() == 0);
    link.fifo_item  = (up_q.size() != 0) ? up_q[0] : 8'h00;
    link.credit_in  = cpipe1 | spur;
  endtask

  task automatic model_reset();
    down_q.delete();
    order_q.delete();
    m_credits = CREDITS;
    m_err     = 1'b0;
    m_valid   = 1'b0;
    m_flit    = 8'h00;
    m_state   = 0;
    cpipe0    = 1'b0;
    cpipe1    = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, then advance the reference model.
  task automatic cycle();
    bit    send, blocked, cin, pop;
    flit_t v, e;
    @(negedge clk);
    send    = reset && enable && (up_q.size() != 0) && (m_credits != 0);
    blocked = reset && enable && (up_q.size() != 0) && (m_credits == 0);
    cin     = link.credit_in;
    chk("fifo_read", link.fifo_read, send);
    chk("link_valid", link.link_valid, m_valid);
    if (m_valid)
      chk("link_flit", link.link_flit, m_flit);
    chk("credits", credits, m_credits);
    chk("state", state, m_state);
    chk("credit_err", credit_err, m_err);
    if (send && cin && m_credits == 1)
      overlap_hits++;
    @(posedge clk);
    if (!reset) begin
      #1 drive();
      return;
    end
    pop = down_en && (down_q.size() != 0);
    if (m_valid)
      chk("down_full_write", (down_q.size() < DOWN_CAP), 1);
    if (pop) begin
      v = down_q.pop_front();
      recv_q.push_back(v);
      if (order_q.size() == 0) begin
        chk("order_underrun", 0, 1);
      end else begin
        e = order_q.pop_front();
        chk("order", v, e);
      end
    end
    if (m_valid)
      down_q.push_back(m_flit);
    cpipe1 = cpipe0;
    cpipe0 = pop;
    if (send) begin
      m_flit = up_q.pop_front();
      order_q.push_back(m_flit);
    end
    m_valid = send;
    m_state = send ? 1 : (blocked ? 2 : 0);
    if (cin && !send && m_credits == CREDITS)
      m_err = 1'b1;
    else
      m_credits = m_credits - int'(send) + int'(cin);
    #1 drive();
  endtask

  initial begin
    int n;
    reset   = 1'b1;
    enable  = 1'b0;
    down_en = 1'b0;
    spur    = 1'b0;
    model_reset();
    drive();
    #1 reset = 1'b0;

    // Reset with an empty local FIFO
    repeat (2) cycle();
    chk("rst_link_flit", link.link_flit, 8'h00);
    reset = 1'b1;
    enable = 1'b1;
    repeat (4) cycle();
    chk("idle_credits", credits, 3);
    chk("idle_state", state, 0);

    // Four flits with the downstream stalled: three go, the fourth starves
    up_q.push_back(8'h11); up_q.push_back(8'h22);
    up_q.push_back(8'h33); up_q.push_back(8'h44);
    drive();
    repeat (6) cycle();
    chk("starved_credits", credits, 0);
    chk("starved_state", state, 2);
    chk("starved_hold", link.fifo_empty, 0);

    // Release the downstream and drain
    down_en = 1'b1;
    repeat (14) cycle();
    chk("drained_credits", credits, 3);
    chk("recv_count", recv_q.size(), 4);
    if (recv_q.size() == 4) begin
      chk("recv0", recv_q[0], 8'h11);
      chk("recv1", recv_q[1], 8'h22);
      chk("recv2", recv_q[2], 8'h33);
      chk("recv3", recv_q[3], 8'h44);
    end

    // Continuous stream: the 4-cycle credit loop forces send and return together at credits=1
    overlap_hits = 0;
    for (int i = 0; i < 8; i++)
      up_q.push_back(flit_t'($urandom));
    drive();
    repeat (30) cycle();
    chk("credit_overlap_seen", (overlap_hits > 0), 1);
    chk("stream_credits", credits, 3);

    // Randomized traffic, enable and downstream stalls
    for (int i = 0; i < 400; i++) begin
      if (($urandom % 3) == 0 && up_q.size() < 8)
        up_q.push_back(flit_t'($urandom));
      enable  = (($urandom % 8) != 0);
      down_en = (($urandom % 4) != 0);
      drive();
      cycle();
    end
    enable  = 1'b1;
    down_en = 1'b1;
    drive();
    n = 0;
    while ((up_q.size() != 0 || order_q.size() != 0) && n < 200) begin
      cycle();
      n++;
    end
    chk("drain_timeout", (n < 200), 1);
    repeat (6) cycle();
    chk("rand_credits", credits, 3);
    chk("rand_err", credit_err, 0);

    // Spurious credit at full count
    spur = 1'b1;
    drive();
    cycle();
    spur = 1'b0;
    drive();
    repeat (4) cycle();
    chk("spur_credits", credits, 3);
    chk("spur_err", credit_err, 1);

    // Reset in the cycle after a pop
    up_q.push_back(8'h5A); up_q.push_back(8'hA5);
    drive();
    n = 0;
    while (!m_valid && n < 10) begin
      cycle();
      n++;
    end
    chk("pop_timeout", m_valid, 1);
    reset = 1'b0;
    model_reset();
    drive();
    @(negedge clk);
    chk("mid_rst_valid", link.link_valid, 0);
    chk("mid_rst_credits", credits, 3);
    chk("mid_rst_err", credit_err, 0);
    chk("mid_rst_read", link.fifo_read, 0);
    repeat (2) cycle();
    reset = 1'b1;
    recv_q.delete();
    up_q.push_back(8'h01); up_q.push_back(8'h02); up_q.push_back(8'h03);
    drive();
    repeat (16) cycle();
    chk("resume_recv", recv_q.size(), 4);
    chk("resume_credits", credits, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_link_tx.md
# noc_link_tx

Credit-based link transmitter that drains a router's local `fifo` and drives the flits across an inter-router link into the downstream router's input `fifo`. It is the read-side counterpart of the FIFO's write interface. It pops the local FIFO only when the downstream buffer is guaranteed to have room, so the downstream `write` never hits `full`. One instance sits on each router output port, between the output FIFO and the link wires.

## Interface
Parameters:
- `FLIT_W`, default `PAYLOAD_SIZE+`ADDR_BITS: flit width, identical to the FIFO item width.
- `CREDITS`, default `FIFO_DEPTH-1: downstream FIFO usable capacity. The FIFO reports full at DEPTH-1 entries.
- `CRED_W`, default $clog2(CREDITS+1): credit counter width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  transmit enable; when 0, no pops and no sends.
- `fifo_empty`  in  1  local FIFO empty flag.
- `fifo_item`  in  FLIT_W  local FIFO head (combinational `item_out`).
- `fifo_read`  out  1  pop strobe to the local FIFO.
- `link_valid`  out  1  flit valid on the link this cycle (drives downstream `write`).
- `link_flit`  out  FLIT_W  flit on the link (drives downstream `item_in`).
- `credit_in`  in  1  one-cycle pulse; the downstream FIFO freed one entry.
- `credits`  out  CRED_W  current credit count.
- `state`  out  2  status: IDLE=0, SEND=1, STARVED=2.
- `credit_err`  out  1  sticky; a credit was returned while the counter was already at CREDITS.

## Operation
- Send condition: send = `enable` & !`fifo_empty` & (`credits` != 0).
- `fifo_read` = send, combinational.
- On send, the head flit is captured into the output register. `link_valid` is 1 in the next cycle.
- With no send, `link_valid` is 0 in the next cycle and `link_flit` holds its last value.
- Credit update each cycle: credits_next = credits − send + `credit_in`.
  - Send and `credit_in` in the same cycle leave the count unchanged.
  - A `credit_in` is not usable in the cycle it arrives; it takes effect one cycle later.
- Overflow: if `credit_in`=1, send=0 and credits==CREDITS, the counter saturates at CREDITS and `credit_err` is set. Only reset clears `credit_err`.
- Underflow is impossible by construction, because send requires credits != 0.
- `state` is registered and reflects the previous cycle's decision:
  - SEND if that cycle sent.
  - STARVED if the FIFO was non-empty and enabled but credits were 0.
  - IDLE otherwise, which includes `enable`=0 and FIFO empty.
  - Encoding 3 is unused and never produced.
- Reset values: `link_valid`=0, `link_flit`=0, `credits`=CREDITS, `state`=IDLE, `credit_err`=0. `fifo_read` is 0 while `reset` is low.
- Reset asserted mid-transfer drops any flit in the output register; no partial handshakes remain. The downstream router must be reset together with this block so that the credit count matches.

## Timing
- Latency: a flit at the FIFO head in cycle t, with credits and enable, appears on `link_valid`/`link_flit` in cycle t+1.
- Throughput is one flit per cycle while credits are nonzero.
- Full-rate streaming needs CREDITS ≥ credit round-trip latency + 1. Below that the block alternates SEND and STARVED; this is not an error.
- There is no combinational path from `credit_in` to any output. `fifo_read` depends only on `enable`, `fifo_empty` and registered `credits`.
- `enable` falling takes effect in the same cycle: no pop occurs. A flit already registered is still presented in the following cycle.

## Structure
- A shared NoC package/include holds the flit width macros (`PAYLOAD_SIZE`, `ADDR_BITS`, `FIFO_LOG2`) and the `state` encodings IDLE/SEND/STARVED.
- The credit counter with saturation and error flag is a natural sub-module, `credit_counter`. It is reusable on the receive side for credit bookkeeping.
- The datapath is one FLIT_W output register plus a valid flop. The control is the send equation plus the status register.

## Test plan
Bench uses CREDITS=3 and a real `fifo` upstream and downstream. The downstream FIFO pops each entry and returns `credit_in` 2 cycles later.
- Reset release with an empty FIFO → `credits`=3, `link_valid`=0, `state`=IDLE, `fifo_read` never asserts.
- Push 0x11, 0x22, 0x33, 0x44 with downstream popping stalled → first three flits appear on consecutive cycles, `credits` goes 3→0, then `state`=STARVED and 0x44 stays in the local FIFO. Downstream FIFO never shows full plus write.
- Release downstream pops → after the credit latency 0x44 is sent, `credits` returns to 3 once drained, and the flit order is 0x11..0x44 with no loss or duplication.
- Same-cycle send and `credit_in` with credits=1 → credits stays 1 and back-to-back flits continue.
- Inject a spurious `credit_in` at credits=3 → `credits` stays 3 and `credit_err`=1 until reset.
- Drop `reset` low in the cycle after a pop → `link_valid`=0 immediately, `credits`=3, `credit_err`=0, and normal operation resumes after release.
